// File: rtl/br_redirect_ctrl.sv
// br_redirect_ctrl: front-end redirect sequencer after branch resolution.
// It detects branch mispredicts in EX, kills wrong-path IF/ID contents, and
// drives a corrected fetch PC over a valid/ready handshake. A WB exception/ertn
// flush has priority over a mispredict from EX.
// Optional feature macro: BR_PERF_CNT_EN adds branch and mispredict counters.
module br_redirect_ctrl #(
  parameter int PC_W       = 32,
  parameter int INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_br_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_br_taken,
  input  logic [PC_W-1:0] ex_br_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  input  logic            wb_flush,
  input  logic [PC_W-1:0] wb_flush_pc,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            flush_if,
  output logic            flush_id,
  output logic            mispredict
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mis_cnt
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  logic [0:0] state;
  logic       mis_cond;
  logic       mis_take;
  logic       flush_any;

  // Fall-through PC wraps modulo 2^PC_W; no carry out is kept.
  function automatic logic [PC_W-1:0] corrected_pc(
    input logic            taken,
    input logic [PC_W-1:0] target,
    input logic [PC_W-1:0] pc
  );
    return taken ? target : pc + PC_W'(INST_BYTES);
  endfunction

  // Mispredict detection and flush generation; flush is forced low during reset.
  always_comb begin
    mis_cond  = ex_br_valid &&
                ((ex_br_taken != ex_pred_taken) ||
                 (ex_br_taken && (ex_br_target != ex_pred_target)));
    mis_take  = (state == ST_IDLE) && !wb_flush && mis_cond;
    flush_any = resetn && ((state == ST_REDIR) || wb_flush || mis_cond);
    flush_if  = flush_any;
    flush_id  = flush_any;
  end

  // Redirect FSM: WB flush wins over EX; PC held until accepted unless WB overwrites it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      mispredict  <= 1'b0;
    end else if (state == ST_IDLE) begin
      mispredict <= mis_take;
      if (wb_flush) begin
        redir_pc    <= wb_flush_pc;
        redir_valid <= 1'b1;
        state       <= ST_REDIR;
      end else if (mis_cond) begin
        redir_pc    <= corrected_pc(ex_br_taken, ex_br_target, ex_pc);
        redir_valid <= 1'b1;
        state       <= ST_REDIR;
      end
    end else begin
      // Branches seen here are on the wrong path and are ignored.
      mispredict <= 1'b0;
      if (wb_flush) begin
        // A handshake completing on this edge consumed the old PC; re-issue the new one.
        redir_pc    <= wb_flush_pc;
        redir_valid <= 1'b1;
      end else if (redir_ready) begin
        redir_valid <= 1'b0;
        state       <= ST_IDLE;
      end
    end
  end

`ifdef BR_PERF_CNT_EN
  // Performance counters: branches resolved in IDLE without a WB flush, and mispredict pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && ex_br_valid && !wb_flush)
        perf_br_cnt <= perf_br_cnt + 32'd1;
      if (mis_take)
        perf_mis_cnt <= perf_mis_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// tb_br_redirect_ctrl: directed plus randomized bench for br_redirect_ctrl,
// checked against a transaction-level model of the redirect behaviour.
module tb_br_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        wb_flush;
  logic [31:0] wb_flush_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        flush_if;
  logic        flush_id;
  logic        mispredict;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: is a redirect outstanding, which PC, and is a pulse due.
  bit          m_busy  = 1'b0;
  bit          m_pulse = 1'b0;
  logic [31:0] m_pc    = '0;

  br_redirect_ctrl #(.PC_W(32), .INST_BYTES(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_br_valid    (ex_br_valid),
    .ex_pc          (ex_pc),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .wb_flush       (wb_flush),
    .wb_flush_pc    (wb_flush_pc),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .redir_ready    (redir_ready),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .mispredict     (mispredict)
`ifdef BR_PERF_CNT_EN
    ,
    .perf_br_cnt    (perf_br_cnt),
    .perf_mis_cnt   (perf_mis_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called at posedge+1), check the combinational
  // flush, advance the model, then check registered outputs after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                      input logic wf, input logic [31:0] wpc, input logic rdy);
    bit          mis;
    logic [31:0] fix;
    ex_br_valid    = v;
    ex_pc          = pc;
    ex_br_taken    = tk;
    ex_br_target   = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    wb_flush       = wf;
    wb_flush_pc    = wpc;
    redir_ready    = rdy;
    #1;
    mis = v && ((tk != ptk) || (tk && (tg != ptg)));
    fix = tk ? tg : 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
    check_eq("flush_if", flush_if, m_busy || wf || mis);
    check_eq("flush_id", flush_id, m_busy || wf || mis);
    if (!m_busy) begin
      m_pulse = 1'b0;
      if (wf) begin
        m_busy = 1'b1;
        m_pc   = wpc;
      end else if (mis) begin
        m_busy  = 1'b1;
        m_pc    = fix;
        m_pulse = 1'b1;
      end
    end else begin
      m_pulse = 1'b0;
      if (wf) m_pc = wpc;
      else if (rdy) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("redir_valid", redir_valid, m_busy);
    check_eq("redir_pc", redir_pc, m_pc);
    check_eq("mispredict", mispredict, m_pulse);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    int pulses;
    resetn = 1'b0;
    ex_br_valid = 0; ex_pc = 0; ex_br_taken = 0; ex_br_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; wb_flush = 0; wb_flush_pc = 0;
    redir_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_redir_valid", redir_valid, 1'b0);
    check_eq("rst_redir_pc", redir_pc, 32'h0);
    check_eq("rst_mispredict", mispredict, 1'b0);
    check_eq("rst_flush_if", flush_if, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Correctly predicted taken branch passes silently.
    step(1, 32'h1c000000, 1, 32'h1c000040, 1, 32'h1c000040, 0, 0, 1);

    // Not-taken mispredict, accepted immediately.
    step(1, 32'h1c000100, 0, 32'h1c000200, 1, 32'h1c000200, 0, 0, 1);
    check_eq("nt_pc", redir_pc, 32'h1c000104);
    check_eq("nt_pulse", mispredict, 1'b1);
    idle(1);
    idle(1);

    // Backpressure: held PC, single pulse.
    pulses = 0;
    step(1, 32'h1c000300, 1, 32'h1c000800, 0, 32'h0, 0, 0, 0);
    pulses += int'(mispredict);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      pulses += int'(mispredict);
      check_eq("bp_pc_hold", redir_pc, 32'h1c000800);
    end
    idle(1);
    check_eq("bp_done", redir_valid, 1'b0);
    check_eq("bp_pulses", pulses, 1);

    // WB flush beats a simultaneous mispredict, then overwrites PC in REDIR.
    step(1, 32'h1c000400, 0, 32'h0, 1, 32'h0, 1, 32'h1c008000, 0);
    check_eq("prio_pc", redir_pc, 32'h1c008000);
    check_eq("prio_nopulse", mispredict, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h1c009000, 0);
    check_eq("prio_overwrite", redir_pc, 32'h1c009000);
    step(0, 0, 0, 0, 0, 0, 1, 32'h1c00a000, 1);
    check_eq("prio_reissue", redir_valid, 1'b1);
    idle(1);

    // Wrap of the fall-through PC.
    step(1, 32'hfffffffc, 0, 32'h0, 1, 32'h1234, 0, 0, 0);
    check_eq("wrap_pc", redir_pc, 32'h0);
    idle(1);

    // Target-only mispredict followed back-to-back by another mispredict.
    step(1, 32'h1c000000, 1, 32'h1c000500, 1, 32'h1c000600, 0, 0, 1);
    check_eq("tgt_pc", redir_pc, 32'h1c000500);
    idle(1);
    step(1, 32'h1c000700, 0, 32'h0, 1, 32'h0, 0, 0, 1);
    check_eq("b2b_pc", redir_pc, 32'h1c000704);
    check_eq("b2b_pulse", mispredict, 1'b1);

    // Reset while a redirect is outstanding.
    ex_br_valid = 0; wb_flush = 0; redir_ready = 0;
    resetn = 1'b0;
    #1;
    check_eq("rstmid_valid", redir_valid, 1'b0);
    check_eq("rstmid_pc", redir_pc, 32'h0);
    check_eq("rstmid_flush", flush_if, 1'b0);
`ifdef BR_PERF_CNT_EN
    check_eq("rstmid_br_cnt", perf_br_cnt, 32'h0);
    check_eq("rstmid_mis_cnt", perf_mis_cnt, 32'h0);
`endif
    m_busy = 1'b0; m_pulse = 1'b0; m_pc = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid_idle", redir_valid, 1'b0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        v, tk, ptk, wf, rdy;
      logic [31:0] pc, tg, ptg, wpc;
      v   = ($urandom_range(0, 1) == 1);
      pc  = ($urandom_range(0, 9) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
      tk  = ($urandom_range(0, 1) == 1);
      ptk = ($urandom_range(0, 9) < 7) ? tk : ~tk;
      tg  = $urandom & 32'hfffffffc;
      ptg = ($urandom_range(0, 9) < 7) ? tg : ($urandom & 32'hfffffffc);
      wf  = ($urandom_range(0, 9) == 0);
      wpc = $urandom & 32'hfffffffc;
      rdy = ($urandom_range(0, 1) == 1);
      step(v, pc, tk, tg, ptk, ptg, wf, wpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
- Sequences front-end redirection after branch resolution.
- Takes the resolved outcome of the branch unit in EX (taken flag and target) plus the prediction carried with the instruction, and detects mispredicts.
- On a mispredict it kills wrong-path IF/ID contents and drives a corrected PC to fetch over a valid/ready handshake.
- Arbitrates that redirect port against the higher-priority WB exception/ertn flush.

Parameters:
- PC_W, 32: PC/target width.
- INST_BYTES, 4: sequential PC increment.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ex_br_valid  in  1  EX holds a valid branch/jump this cycle, resolved by the branch unit.
- ex_pc  in  PC_W  PC of that branch.
- ex_br_taken  in  1  resolved taken.
- ex_br_target  in  PC_W  resolved target.
- ex_pred_taken  in  1  predicted taken.
- ex_pred_target  in  PC_W  predicted target.
- wb_flush  in  1  exception/ertn flush from WB.
- wb_flush_pc  in  PC_W  handler/era PC.
- redir_valid  out  1  redirect request to fetch.
- redir_pc  out  PC_W  redirect PC.
- redir_ready  in  1  fetch accepts redirect.
- flush_if  out  1  kill IF stage contents.
- flush_id  out  1  kill ID stage contents.
- mispredict  out  1  single-cycle pulse on mispredict detection.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; redir_valid=0; redir_pc=0; mispredict=0; pending-source flag cleared. flush_if=0 and flush_id=0 while reset is asserted.
- Mispredict condition: ex_br_valid && ((ex_br_taken != ex_pred_taken) || (ex_br_taken && ex_br_target != ex_pred_target)).
- Corrected PC: ex_br_taken ? ex_br_target : ex_pc + INST_BYTES, computed modulo 2^PC_W (wraps, no carry out).
- States: IDLE and REDIR.
- IDLE, wb_flush=1:
  - flush_if=flush_id=1 combinationally this cycle.
  - Next edge: redir_pc<=wb_flush_pc, redir_valid<=1, state<=REDIR.
  - A simultaneous mispredict is ignored (the branch is younger than the faulting instruction); mispredict stays 0.
- IDLE, mispredict condition true and no wb_flush:
  - flush_if=flush_id=1 combinationally this cycle.
  - Next edge: redir_pc<=corrected PC, redir_valid<=1, mispredict<=1 for exactly one cycle, state<=REDIR.
- IDLE, otherwise: all outputs 0; correctly predicted branches pass silently.
- REDIR:
  - redir_valid=1; flush_if=flush_id=1 every cycle, so anything fetched before acceptance is killed.
  - ex_br_valid is ignored (wrong path).
  - redir_pc is stable while redir_valid=1 && !redir_ready, except that wb_flush in REDIR overwrites redir_pc with wb_flush_pc at the next edge. If that edge also completes a handshake, the handshake consumes the old PC and the new wb_flush_pc is re-issued (stay REDIR).
  - redir_valid && redir_ready: handshake completes at this edge; next state IDLE, redir_valid<=0.
- Latency: detection cycle N produces flush in N; redir_valid rises N+1; fastest return to IDLE is N+2 with redir_ready=1 at N+1.
- Back-to-back: a new mispredict in the first IDLE cycle after return is handled normally.
- Reset mid-REDIR: drops the request immediately; no handshake is completed.

Optional Feature:
- Macro BR_PERF_CNT_EN. When defined, add outputs perf_br_cnt[31:0] and perf_mis_cnt[31:0]:
  - perf_br_cnt increments on each ex_br_valid accepted in IDLE without wb_flush.
  - perf_mis_cnt increments on each mispredict pulse.
  - Both are reset to 0 and wrap at 2^32.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Correct prediction: ex_br_valid=1, pc=0x1c000000, taken=1, target=0x1c000040, pred_taken=1, pred_target=0x1c000040 -> no flush, redir_valid stays 0, mispredict 0.
- Not-taken mispredict: pc=0x1c000100, taken=0, pred_taken=1 -> flush_if/id same cycle; next cycle redir_valid=1, redir_pc=0x1c000104, mispredict pulse; redir_ready=1 -> IDLE.
- Backpressure: taken=1, target=0x1c000800, pred_taken=0, redir_ready=0 for 3 cycles -> redir_pc held at 0x1c000800, flush_if/id high all 4 REDIR cycles, single handshake, single mispredict pulse.
- Priority: wb_flush=1 (pc 0x1c008000) with simultaneous mispredict -> redir_pc=0x1c008000, mispredict 0. wb_flush during REDIR with redir_ready=0 -> redir_pc updates to new wb_flush_pc.
- Wrap and target-only mispredict: pc=0xfffffffc, taken=0, pred_taken=1 -> redir_pc=0x00000000. Also taken=1 with pred_target differing -> redirect to ex_br_target.
- Reset mid-REDIR: deassert resetn while redir_valid=1 -> redir_valid=0 immediately, state IDLE after release; with BR_PERF_CNT_EN, both counters read 0.
